// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the 3x3 Sobel line-buffer datapath: primes the window,
// paces shift/emit pairs, flushes the tail with zeros and masks border outputs.
module sobel_frame_ctrl #(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int DWIDTH     = 8
) (
    input  logic              clock,
    input  logic              reset,
    output logic              in_rd_en,
    input  logic [DWIDTH-1:0] in_dout,
    input  logic              in_empty,
    output logic              win_shift,
    output logic [DWIDTH-1:0] win_din,
    input  logic [DWIDTH-1:0] grad,
    output logic              out_wr_en,
    output logic [DWIDTH-1:0] out_din,
    input  logic              out_full,
    output logic              busy,
    output logic              frame_done
);
    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int ICW  = $clog2(NPIX + 1);
    localparam int FCW  = $clog2(IMG_WIDTH + 2);
    localparam int XW   = $clog2(IMG_WIDTH);
    localparam int YW   = $clog2(IMG_HEIGHT + 1);

    localparam logic [ICW-1:0] PRIME_LAST = ICW'(IMG_WIDTH);
    localparam logic [ICW-1:0] IN_LAST    = ICW'(NPIX);
    localparam logic [FCW-1:0] FL_LAST    = FCW'(IMG_WIDTH + 1);
    localparam logic [XW-1:0]  X_LAST     = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]  Y_LAST     = YW'(IMG_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_RUN, S_EMIT, S_FLUSH, S_FLUSH_EMIT, S_DONE
    } state_t;

    state_t         state;
    logic [ICW-1:0] in_cnt;
    logic [FCW-1:0] fl_cnt;
    logic [XW-1:0]  out_x;
    logic [YW-1:0]  out_y;
    logic           border;

    always_comb begin
        in_rd_en  = 1'b0;
        win_shift = 1'b0;
        out_wr_en = 1'b0;
        win_din   = '0;
        if (!reset) begin
            case (state)
                S_IDLE, S_PRIME, S_RUN: begin
                    in_rd_en  = !in_empty;
                    win_shift = !in_empty;
                    win_din   = in_dout;
                end
                S_FLUSH:               win_shift = 1'b1;
                S_EMIT, S_FLUSH_EMIT:  out_wr_en = !out_full;
                default:               ;
            endcase
        end
        // Wrapped/stale window contents only ever land on these positions.
        border  = (out_x == '0) || (out_x == X_LAST) || (out_y == '0) || (out_y == Y_LAST);
        out_din = (reset || border) ? '0 : grad;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            in_cnt     <= '0;
            fl_cnt     <= '0;
            out_x      <= '0;
            out_y      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: if (!in_empty) begin
                    in_cnt <= ICW'(1);
                    busy   <= 1'b1;
                    state  <= S_PRIME;
                end
                S_PRIME: if (!in_empty) begin
                    in_cnt <= in_cnt + 1'b1;
                    if (in_cnt == PRIME_LAST) state <= S_RUN;
                end
                S_RUN: if (!in_empty) begin
                    in_cnt <= in_cnt + 1'b1;
                    state  <= S_EMIT;
                end
                S_EMIT: if (!out_full) state <= (in_cnt < IN_LAST) ? S_RUN : S_FLUSH;
                S_FLUSH: begin
                    fl_cnt <= fl_cnt + 1'b1;
                    state  <= S_FLUSH_EMIT;
                end
                S_FLUSH_EMIT: if (!out_full) begin
                    if (fl_cnt < FL_LAST) begin
                        state <= S_FLUSH;
                    end else begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    in_cnt <= '0;
                    fl_cnt <= '0;
                    out_x  <= '0;
                    out_y  <= '0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // Output position follows every write, in both emit phases.
            if (out_wr_en) begin
                if (out_x == X_LAST) begin
                    out_x <= '0;
                    out_y <= out_y + 1'b1;
                end else begin
                    out_x <= out_x + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl on a 4x3 frame: source FIFO, window/Sobel engine
// stand-in, and a 2D image-based scoreboard for every output write.
module tb_sobel_frame_ctrl;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;
    localparam int WD   = 2 * W + 3;
    localparam int C    = W + 1;
    localparam int TL = C + W + 1, T = C + W, TR = C + W - 1, L = C + 1, R = C - 1;
    localparam int BL = C - W + 1, B = C - W, BR = C - W - 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_rd_en, in_empty, win_shift, out_wr_en, out_full, busy, frame_done;
    logic [7:0] in_dout, win_din, grad, out_din;

    sobel_frame_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH(8)) dut (
        .clock(clock), .reset(reset), .in_rd_en(in_rd_en), .in_dout(in_dout),
        .in_empty(in_empty), .win_shift(win_shift), .win_din(win_din), .grad(grad),
        .out_wr_en(out_wr_en), .out_din(out_din), .out_full(out_full), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // show-ahead source FIFO
    logic [7:0] src [0:127];
    int         src_n = 0, head = 0;
    logic       hold_empty = 1'b0, fifo_flush = 1'b0;
    assign in_empty = (head >= src_n) || hold_empty;
    assign in_dout  = (head < src_n) ? src[head[6:0]] : 8'h00;
    always @(posedge clock) begin
        if (fifo_flush)    head <= src_n;
        else if (in_rd_en) head <= head + 1;
    end

    // window + gradient engine stand-in: grad valid the cycle after a shift
    logic [7:0] win [0:WD-1] = '{default: 8'h00};
    int gx, gy, mag;
    always @(posedge clock) begin
        if (win_shift) begin
            win[0] <= win_din;
            for (int j = 1; j < WD; j++) win[j] <= win[j-1];
        end
    end
    always_comb begin
        gx   = (int'(win[TR]) + 2*int'(win[R]) + int'(win[BR]))
             - (int'(win[TL]) + 2*int'(win[L]) + int'(win[BL]));
        gy   = (int'(win[BL]) + 2*int'(win[B]) + int'(win[BR]))
             - (int'(win[TL]) + 2*int'(win[T]) + int'(win[TR]));
        mag  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        grad = (mag > 255) ? 8'd255 : mag[7:0];
    end

    // images and reference model in plain 2D coordinates
    int img_b [NPIX] = '{0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 10, 50};
    int img_c [NPIX] = '{0, 0, 0, 0,   0, 0, 0, 0,   200, 200, 200, 200};
    int cur   [NPIX];
    int exp_q [$];

    function automatic int px(input int x, input int y);
        return cur[y*W + x];
    endfunction

    function automatic int expv(input int x, input int y);
        int sx, sy, s;
        if (x == 0 || x == W-1 || y == 0 || y == H-1) return 0;
        sx = (px(x+1,y-1) + 2*px(x+1,y) + px(x+1,y+1)) - (px(x-1,y-1) + 2*px(x-1,y) + px(x-1,y+1));
        sy = (px(x-1,y+1) + 2*px(x,y+1) + px(x+1,y+1)) - (px(x-1,y-1) + 2*px(x,y-1) + px(x+1,y-1));
        s  = (sx < 0 ? -sx : sx) + (sy < 0 ? -sy : sy);
        return (s > 255) ? 255 : s;
    endfunction

    task automatic load_frame(input int which);
        for (int i = 0; i < NPIX; i++) cur[i] = (which == 0) ? img_b[i] : img_c[i];
        for (int i = 0; i < NPIX; i++) src[src_n + i] = 8'(cur[i]);
        src_n = src_n + NPIX;
        for (int p = 0; p < NPIX; p++) exp_q.push_back(expv(p % W, p / W));
    endtask

    // per-cycle compare process
    int start_cyc = 0, wr_cnt = 0, tot_wr = 0, done_n = 0, last_len = 0, last_wr = 0;
    int got [0:63];
    always @(negedge clock) begin
        if (reset) begin
            chk("reset_outs", {in_rd_en, win_shift, out_wr_en, busy, frame_done}, 0);
            chk("reset_out_din", out_din, 0);
        end else begin
            if (in_empty) chk("pop_while_empty", in_rd_en, 0);
            if (out_full) chk("write_while_full", out_wr_en, 0);
            if (in_rd_en) chk("win_din_pop", win_din, in_dout);
            if (win_shift && !in_rd_en) chk("win_din_flush", win_din, 0);
            if (in_rd_en && !busy) begin
                start_cyc = cyc;
                wr_cnt    = 0;
            end
            if (out_wr_en) begin
                if (exp_q.size() == 0) chk("extra_write", 1, 0);
                else chk("out_din", out_din, exp_q.pop_front());
                if (wr_cnt < 64) got[wr_cnt] = int'(out_din);
                wr_cnt++;
                tot_wr++;
            end
            if (frame_done) begin
                done_n++;
                last_len = cyc - start_cyc + 1;
                last_wr  = wr_cnt;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int target);
        int budget = 0;
        while (done_n < target && budget < 400) begin
            tick();
            budget++;
        end
        chk("frame_done_count", done_n, target);
    endtask

    initial begin
        int wr0;
        out_full = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        for (int i = 0; i < NPIX; i++) cur[i] = img_b[i];
        chk("model_pin_b11", expv(1, 1), 20);
        chk("model_pin_b21", expv(2, 1), 120);
        for (int i = 0; i < NPIX; i++) cur[i] = img_c[i];
        chk("model_pin_c11", expv(1, 1), 255);
        chk("model_pin_c00", expv(0, 0), 0);
        reset = 1'b0;
        tick();

        // frame with no stalls
        load_frame(0);
        wait_done(1);
        chk("nostall_len", last_len, 30);
        chk("nostall_writes", last_wr, 12);
        chk("nostall_p5", got[5], 20);
        chk("nostall_p6", got[6], 120);
        chk("nostall_p4", got[4], 0);
        tick();
        chk("busy_after", busy, 0);
        chk("done_single", frame_done, 0);

        // out_full for 3 cycles during the third emit
        load_frame(0);
        repeat (10) tick();
        for (int s = 0; s < 3; s++) begin
            out_full = 1'b1;
            #1;
            chk("stall_pop", in_rd_en, 0);
            chk("stall_shift", win_shift, 0);
            chk("stall_write", out_wr_en, 0);
            tick();
        end
        out_full = 1'b0;
        wait_done(2);
        chk("stall_len", last_len, 33);
        chk("stall_writes", last_wr, 12);
        chk("stall_p6", got[6], 120);
        tick();

        // source starving every other cycle during the run phase
        load_frame(0);
        repeat (5) tick();
        for (int k = 0; k < 200 && done_n < 3; k++) begin
            hold_empty = ~hold_empty;
            tick();
        end
        hold_empty = 1'b0;
        chk("starve_done", done_n, 3);
        chk("starve_writes", last_wr, 12);
        tick();

        // two frames back to back
        wr0 = tot_wr;
        load_frame(0);
        load_frame(0);
        wait_done(5);
        chk("b2b_writes_total", tot_wr - wr0, 24);
        chk("b2b_second_len", last_len, 30);
        chk("b2b_second_p5", got[5], 20);
        chk("b2b_second_p6", got[6], 120);
        tick();

        // reset mid-frame at in_cnt=7, then a clean frame
        load_frame(1);
        repeat (8) tick();
        chk("pre_abort_busy", busy, 1);
        reset      = 1'b1;
        fifo_flush = 1'b1;
        #1;
        chk("abort_write", out_wr_en, 0);
        chk("abort_pop", in_rd_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_out_din", out_din, 0);
        exp_q.delete();
        tick();
        fifo_flush = 1'b0;
        reset      = 1'b0;
        tick();
        load_frame(1);
        wait_done(6);
        chk("post_abort_writes", last_wr, 12);
        chk("post_abort_len", last_len, 30);
        chk("post_abort_p5", got[5], 255);
        chk("post_abort_p9", got[9], 0);
        tick();
        chk("leftover_expected", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
